// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the p2s serial transmitter.
// Optional build macro P2S_LSB_FIRST_EN is consumed by p2s_shift_tx.
package p2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } p2s_state_e;

  // Serial half-period in Cp cycles.
  function automatic int unsigned p2s_hp(input int unsigned div);
    return 32'd1 << div;
  endfunction

  // Phase counter spans one full bit (2*HP cycles) and wraps naturally.
  function automatic int unsigned p2s_phase_w(input int unsigned div);
    return div + 1;
  endfunction

  function automatic int unsigned p2s_cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/p2s_tick_gen.sv
// Bit-phase counter for p2s_shift_tx: flags the end of the sclk low phase
// (mid_tick) and the end of a bit (end_tick) while enabled.
module p2s_tick_gen
  import p2s_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic Cp,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic mid_tick,
  output logic end_tick
);

  localparam int unsigned PW = p2s_phase_w(DIV);
  localparam logic [PW-1:0] MID_PHASE = PW'(p2s_hp(DIV) - 1);
  localparam logic [PW-1:0] END_PHASE = '1;

  logic [PW-1:0] phase;

  always_ff @(posedge Cp or posedge Rst) begin
    if (Rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + 1'b1;
    end
  end

  assign mid_tick = en && (phase == MID_PHASE);
  assign end_tick = en && (phase == END_PHASE);

endmodule

// File: rtl/p2s_shift_tx.sv
// Parallel-to-serial transmitter for 74HC595-style DFF chains: shifts a WIDTH-bit
// word out on sdata/sclk, strobes sload, then pulses done. Build macro: P2S_LSB_FIRST_EN.
module p2s_shift_tx
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DIV   = 1
) (
  input  logic             Cp,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdata,
  output logic             sload
);

  localparam int unsigned CW = p2s_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  p2s_state_e       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_sh;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             busy_nxt, done_nxt, sclk_nxt, sload_nxt;
  logic             accept, tick_en, mid_tick, end_tick;

`ifdef P2S_LSB_FIRST_EN
  localparam int unsigned OUT_IDX = 0;
  assign shreg_sh = {1'b0, shreg[WIDTH-1:1]};
`else
  localparam int unsigned OUT_IDX = WIDTH - 1;
  assign shreg_sh = {shreg[WIDTH-2:0], 1'b0};
`endif

  // The register is fully drained after the last shift, so sdata reads 0
  // through LATCH/DONE/IDLE without a separate output flop.
  assign sdata   = shreg[OUT_IDX];
  assign accept  = (state == IDLE) && start;
  assign tick_en = (state == SHIFT) || (state == LATCH);

  p2s_tick_gen #(.DIV(DIV)) u_tick (
    .Cp       (Cp),
    .Rst      (Rst),
    .clr      (accept),
    .en       (tick_en),
    .mid_tick (mid_tick),
    .end_tick (end_tick)
  );

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    sclk_nxt    = sclk;
    sload_nxt   = sload;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          shreg_nxt   = din;
          bit_cnt_nxt = '0;
          busy_nxt    = 1'b1;
          sclk_nxt    = 1'b0;
        end
      end
      SHIFT: begin
        if (mid_tick) begin
          sclk_nxt = 1'b1;
        end else if (end_tick) begin
          sclk_nxt    = 1'b0;
          shreg_nxt   = shreg_sh;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt   = LATCH;
            bit_cnt_nxt = '0;
            sload_nxt   = 1'b1;
          end
        end
      end
      // Phase wrapped to 0 on the last end_tick, so mid_tick marks HP cycles.
      LATCH: begin
        if (mid_tick) begin
          state_nxt = DONE;
          sload_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Cp or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      sload   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sclk    <= sclk_nxt;
      sload   <= sload_nxt;
    end
  end

endmodule

// File: tb/tb_p2s_shift_tx.sv
// Self-checking bench for p2s_shift_tx: cycle-indexed reference model plus a
// word scoreboard fed at start acceptance and drained on each done pulse.
module tb_p2s_shift_tx;

  localparam int W   = 8;
  localparam int DV  = 1;
  localparam int HP  = 2;
  localparam int T1  = W * 2 * HP + HP;
  localparam int W2  = 4;
  localparam int DV2 = 0;
  localparam int HP2 = 1;
  localparam int T2  = W2 * 2 * HP2 + HP2;

  logic          Cp, Rst;
  logic          start, start2;
  logic [W-1:0]  din;
  logic [W2-1:0] din2;
  logic busy, done, sclk, sdata, sload;
  logic busy2, done2, sclk2, sdata2, sload2;

  p2s_shift_tx #(.WIDTH(W), .DIV(DV)) dut (
    .Cp(Cp), .Rst(Rst), .start(start), .din(din),
    .busy(busy), .done(done), .sclk(sclk), .sdata(sdata), .sload(sload)
  );

  p2s_shift_tx #(.WIDTH(W2), .DIV(DV2)) dut2 (
    .Cp(Cp), .Rst(Rst), .start(start2), .din(din2),
    .busy(busy2), .done(done2), .sclk(sclk2), .sdata(sdata2), .sload(sload2)
  );

  initial Cp = 1'b0;
  always #5 Cp = ~Cp;

  // Expected {busy,done,sclk,sdata,sload} in cycle k = t+1-cnt of a transfer.
  function automatic logic [4:0] exp_vec(input int cnt, input logic [63:0] word,
                                         input int w, input int hp);
    int k, sh, t, bi;
    logic b;
    if (cnt == 0) return 5'b0;
    sh = w * 2 * hp;
    t  = sh + hp;
    k  = t + 1 - cnt;
    b  = 1'b0;
    if (k < sh) begin
      bi = k / (2 * hp);
`ifdef P2S_LSB_FIRST_EN
      b = word[bi];
`else
      b = word[w - 1 - bi];
`endif
    end
    return {k < t, k == t, (k < sh) && ((k % (2 * hp)) >= hp), b, (k >= sh) && (k < t)};
  endfunction

  int            m_cnt = 0, m2_cnt = 0, m_acc = 0;
  logic [W-1:0]  m_word = '0;
  logic [W2-1:0] m2_word = '0;
  logic [W-1:0]  exp_q[$];

  always @(posedge Cp or posedge Rst) begin
    if (Rst) begin
      if (m_cnt > 1) void'(exp_q.pop_back());
      m_cnt  = 0;
      m2_cnt = 0;
    end else begin
      if (m_cnt == 0) begin
        if (start) begin
          m_word = din;
          exp_q.push_back(din);
          m_cnt = T1 + 1;
          m_acc++;
        end
      end else m_cnt--;
      if (m2_cnt == 0) begin
        if (start2) begin
          m2_word = din2;
          m2_cnt  = T2 + 1;
        end
      end else m2_cnt--;
    end
  end

  int           n_cmp = 0, n_err = 0;
  logic         prev_sclk = 1'b0;
  logic [W-1:0] rx = '0;
  int           nbits = 0;
  logic         end_req = 1'b0, end_ack = 1'b0;

  always @(negedge Cp) begin
    logic [4:0]   got, e;
    logic [W-1:0] ew;
    got = {busy, done, sclk, sdata, sload};
    e   = exp_vec(m_cnt, 64'(m_word), W, HP);
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL outputs_w8 t=%0t got=%b exp=%b (busy,done,sclk,sdata,sload)", $time, got, e);
    end
    got = {busy2, done2, sclk2, sdata2, sload2};
    e   = exp_vec(m2_cnt, 64'(m2_word), W2, HP2);
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL outputs_w4 t=%0t got=%b exp=%b (busy,done,sclk,sdata,sload)", $time, got, e);
    end
    if (Rst) begin
      prev_sclk = 1'b0;
      nbits     = 0;
      rx        = '0;
    end else begin
      if (sclk && !prev_sclk) begin
`ifdef P2S_LSB_FIRST_EN
        rx = {sdata, rx[W-1:1]};
`else
        rx = {rx[W-2:0], sdata};
`endif
        nbits++;
      end
      prev_sclk = sclk;
      if (done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL word_sb t=%0t got=%h exp=<no pending transfer>", $time, rx);
        end else begin
          ew = exp_q.pop_front();
          if (rx !== ew || nbits != W) begin
            n_err++;
            $display("FAIL word_sb t=%0t got=%h/%0d bits exp=%h/%0d bits", $time, rx, nbits, ew, W);
          end
        end
        nbits = 0;
      end
    end
    if (end_req && !end_ack) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic pulse(input logic [W-1:0] w);
    start = 1'b1;
    din   = w;
    @(negedge Cp);
    start = 1'b0;
    din   = W'($urandom);
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (m_cnt != target && n < 500) begin
      @(negedge Cp);
      n++;
    end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; din = '0; start2 = 1'b0; din2 = '0;
    repeat (3) @(negedge Cp);
    Rst = 1'b0;
    @(negedge Cp);

    // Directed A5 transfer with din scrambled right after capture.
    pulse(8'hA5);
    wait_cnt(0);
    repeat (2) @(negedge Cp);

    // Start held high: back-to-back transfers, din changed mid-transfer.
    begin
      int base = m_acc;
      int n = 0;
      start = 1'b1;
      din   = 8'hA5;
      repeat (5) @(negedge Cp);
      din = 8'h3C;
      while (m_acc < base + 2 && n < 200) begin
        @(negedge Cp);
        n++;
      end
      start = 1'b0;
      wait_cnt(0);
    end
    repeat (2) @(negedge Cp);

    // Asynchronous reset in the middle of a transfer, then a clean transfer.
    pulse(W'($urandom));
    repeat (12) @(negedge Cp);
    @(posedge Cp);
    #2 Rst = 1'b1;
    repeat (2) @(negedge Cp);
    Rst = 1'b0;
    @(negedge Cp);
    pulse(8'hC3);
    wait_cnt(0);

    // Start pulses during LATCH and DONE must be ignored.
    pulse(8'h01);
    wait_cnt(HP + 1);
    start = 1'b1;
    @(negedge Cp);
    start = 1'b0;
    wait_cnt(1);
    start = 1'b1;
    @(negedge Cp);
    start = 1'b0;
    repeat (6) @(negedge Cp);

    // Random start/din activity; the model decides which starts are accepted.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      din   = W'($urandom);
      @(negedge Cp);
    end
    start = 1'b0;
    wait_cnt(0);

    // DIV=0, WIDTH=4 instance.
    start2 = 1'b1;
    din2   = 4'b1001;
    @(negedge Cp);
    start2 = 1'b0;
    din2   = 4'b0110;
    repeat (12) @(negedge Cp);
    for (int i = 0; i < 60; i++) begin
      start2 = ($urandom_range(0, 2) == 0);
      din2   = W2'($urandom);
      @(negedge Cp);
    end
    start2 = 1'b0;
    repeat (12) @(negedge Cp);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge Cp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
